// File: rtl/inst_fetch_buf.sv
// Purpose: fetch stage; issues ROM word reads for each PC and buffers {pc, inst} pairs in a show-ahead FIFO.
// Latency: an accepted request reaches out_valid ROM_LAT+1 cycles later when the FIFO is empty.
// Backpressure: out_ready stalls the FIFO; requests without credit (count + inflight) are dropped and flagged.
module inst_fetch_buf #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inst_ce,
    input  logic [ADDR_W-1:0]         pc,
    output logic                      rom_en,
    output logic [ADDR_W-3:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [DATA_W-1:0]         out_inst,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      misalign
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    // Tag pipeline mirrors the ROM read latency so the returning word meets its PC.
    logic [ROM_LAT-1:0]  tag_vld;
    logic [ADDR_W-1:0]   tag_pc [ROM_LAT];
    logic [CNT_W:0]      inflight;

    logic                aligned;
    logic                accept;
    logic                push;
    logic                pop;

    logic [ADDR_W-1:0]   mem_pc   [DEPTH];
    logic [DATA_W-1:0]   mem_inst [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;

    assign aligned = (pc[1:0] == 2'b00);

    // Reads still travelling through the ROM hold a reserved FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, tag_vld[i]};
        end
    end

    // Credit uses the registered count only, so a same-cycle pop never frees a slot early.
    assign accept = inst_ce && !reset && aligned && (({1'b0, count_q} + inflight) < DEPTH_C);

    assign rom_en    = accept;
    assign rom_addr  = pc[ADDR_W-1:2];
    assign push      = tag_vld[ROM_LAT-1] && !reset;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign out_pc    = out_valid ? mem_pc[rd_ptr]   : '0;
    assign out_inst  = out_valid ? mem_inst[rd_ptr] : '0;

    // Tag valid bits advance every cycle; reset discards reads already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= accept;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
            end
        end
    end

    // Tag PCs travel alongside the valid bits; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        tag_pc[0] <= pc;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_pc[i] <= tag_pc[i-1];
        end
    end

    // Storage write: pair the returning ROM word with the PC that requested it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= tag_pc[ROM_LAT-1];
            mem_inst[wr_ptr] <= rom_rdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            if (inst_ce && aligned && !accept) begin
                overflow <= 1'b1;
            end
            if (inst_ce && !aligned) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: two instances (ROM latency 1 and 2) driven with the same stimulus,
// each compared every cycle against a queue-style reference model, plus directed checks.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_inst_fetch_buf;

    localparam int DEPTH = 4;

    logic               clk;
    logic               reset;
    logic               inst_ce;
    logic [31:0]        pc;
    logic               out_ready;

    logic [1:0]         rom_en;
    logic [1:0][29:0]   rom_addr;
    logic [1:0][31:0]   rom_rdata;
    logic [1:0]         out_valid;
    logic [1:0][31:0]   out_pc;
    logic [1:0][31:0]   out_inst;
    logic [1:0][2:0]    count;
    logic [1:0]         overflow;
    logic [1:0]         misalign;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    inst_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ROM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .inst_ce(inst_ce), .pc(pc),
        .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_rdata(rom_rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_pc(out_pc[0]),
        .out_inst(out_inst[0]), .count(count[0]), .overflow(overflow[0]), .misalign(misalign[0])
    );

    inst_fetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ROM_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .inst_ce(inst_ce), .pc(pc),
        .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_rdata(rom_rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_pc(out_pc[1]),
        .out_inst(out_inst[1]), .count(count[1]), .overflow(overflow[1]), .misalign(misalign[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a scrambled function of the word address.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        return {a[13:0], 2'b10, ~a[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous ROMs: latency 1 for u_lat1, latency 2 for u_lat2; address captured only on enable.
    logic [29:0] ra1, ra2a, ra2b;
    always @(posedge clk) begin
        if (rom_en[0]) ra1 <= rom_addr[0];
        if (rom_en[1]) ra2a <= rom_addr[1];
        ra2b <= ra2a;
    end
    assign rom_rdata[0] = rom_word(ra1);
    assign rom_rdata[1] = rom_word(ra2b);

    // Reference model: buffered PCs in order (index 0 = head) and outstanding reads with due cycle.
    logic [31:0] m_pc  [2][16];
    int          m_size[2];
    logic [31:0] f_pc  [2][8];
    int          f_due [2][8];
    int          f_cnt [2];
    bit          m_ovf [2];
    bit          m_mis [2];
    bit          exp_acc[2];

    // Snapshots of what was seen at the last sample point.
    logic        s_valid[2];
    logic [31:0] s_pc   [2];
    logic [2:0]  s_cnt  [2];
    logic        s_en   [2];
    logic        s_ovf  [2];
    logic        s_mis  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int k);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        ev    = (m_size[k] != 0);
        epc   = ev ? m_pc[k][0] : 32'h0;
        einst = ev ? rom_word(epc[31:2]) : 32'h0;
        exp_acc[k] = inst_ce && !reset && (pc[1:0] == 2'b00) && (m_size[k] + f_cnt[k] < DEPTH);
        chk($sformatf("rom_en[%0d]", k), 64'(rom_en[k]), 64'(exp_acc[k]));
        if (exp_acc[k]) chk($sformatf("rom_addr[%0d]", k), 64'(rom_addr[k]), 64'(pc[31:2]));
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(ev));
        chk($sformatf("count[%0d]", k), 64'(count[k]), 64'(m_size[k]));
        chk($sformatf("out_pc[%0d]", k), 64'(out_pc[k]), 64'(epc));
        chk($sformatf("out_inst[%0d]", k), 64'(out_inst[k]), 64'(einst));
        chk($sformatf("overflow[%0d]", k), 64'(overflow[k]), 64'(m_ovf[k]));
        chk($sformatf("misalign[%0d]", k), 64'(misalign[k]), 64'(m_mis[k]));
        s_valid[k] = out_valid[k];
        s_pc[k]    = out_pc[k];
        s_cnt[k]   = count[k];
        s_en[k]    = rom_en[k];
        s_ovf[k]   = overflow[k];
        s_mis[k]   = misalign[k];
    endtask

    task automatic update(input int k);
        if (reset) begin
            m_size[k] = 0;
            f_cnt[k]  = 0;
            m_ovf[k]  = 1'b0;
            m_mis[k]  = 1'b0;
        end else begin
            if (m_size[k] > 0 && out_ready) begin
                for (int i = 0; i < m_size[k] - 1; i++) m_pc[k][i] = m_pc[k][i+1];
                m_size[k]--;
            end
            if (f_cnt[k] > 0 && f_due[k][0] == cyc) begin
                m_pc[k][m_size[k]] = f_pc[k][0];
                m_size[k]++;
                for (int i = 0; i < f_cnt[k] - 1; i++) begin
                    f_pc[k][i]  = f_pc[k][i+1];
                    f_due[k][i] = f_due[k][i+1];
                end
                f_cnt[k]--;
            end
            if (exp_acc[k]) begin
                f_pc[k][f_cnt[k]]  = pc;
                f_due[k][f_cnt[k]] = cyc + k + 1;
                f_cnt[k]++;
            end
            if (inst_ce && pc[1:0] != 2'b00) m_mis[k] = 1'b1;
            if (inst_ce && pc[1:0] == 2'b00 && !exp_acc[k]) m_ovf[k] = 1'b1;
        end
    endtask

    task automatic cycle(input logic ce, input logic [31:0] p, input logic rdy, input logic rst);
        inst_ce   = ce;
        pc        = p;
        out_ready = rdy;
        reset     = rst;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        chk("push_into_full[0]", {63'd0, (u_lat1.push && (u_lat1.count == 3'd4))}, 64'd0);
        chk("push_into_full[1]", {63'd0, (u_lat2.push && (u_lat2.count == 3'd4))}, 64'd0);
        @(posedge clk);
        update(0);
        update(1);
        cyc++;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev[2];
        int          npop[2];
        logic [31:0] rp;
        logic        ce, rdy, rst;

        for (int k = 0; k < 2; k++) begin
            m_size[k] = 0; f_cnt[k] = 0; m_ovf[k] = 1'b0; m_mis[k] = 1'b0; exp_acc[k] = 1'b0;
        end
        reset = 1'b1; inst_ce = 1'b0; pc = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", 64'(s_valid[k]), 64'd0);
            chk("rst_count", 64'(s_cnt[k]), 64'd0);
            chk("rst_out_pc", 64'(s_pc[k]), 64'd0);
            chk("rst_flags", {62'd0, s_ovf[k], s_mis[k]}, 64'd0);
        end

        // Streaming with decode always ready
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
            if (i == 1) chk("strm_valid_c1", 64'(s_valid[0]), 64'd0);
            if (i == 2) begin
                chk("strm_valid_c2", 64'(s_valid[0]), 64'd1);
                chk("strm_pc_c2", 64'(s_pc[0]), 64'd0);
            end
            if (i == 3) chk("strm_pc_c3", 64'(s_pc[0]), 64'd4);
            if (i >= 2) chk("strm_count", 64'(s_cnt[0]), 64'd1);
            chk("strm_ovf", 64'(s_ovf[0]), 64'd0);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Backpressure fill, then hold, then drain
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(i * 4), 1'b0, 1'b0);
            if (i == 3) chk("fill_accept_12", 64'(s_en[0]), 64'd1);
            if (i == 4) chk("fill_drop_16", 64'(s_en[0]), 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                chk("hold_pc", 64'(s_pc[k]), 64'd0);
                chk("hold_count", 64'(s_cnt[k]), 64'd4);
                chk("fill_overflow", 64'(s_ovf[k]), 64'd1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            for (int k = 0; k < 2; k++) chk("drain_pc", 64'(s_pc[k]), 64'(i * 4));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned request is dropped; next aligned one goes through
        cycle(1'b1, 32'h6, 1'b1, 1'b0);
        chk("mis_en[0]", 64'(s_en[0]), 64'd0);
        chk("mis_en[1]", 64'(s_en[1]), 64'd0);
        cycle(1'b1, 32'h8, 1'b1, 1'b0);
        chk("mis_next_en", 64'(s_en[0]), 64'd1);
        chk("mis_flag", 64'(s_mis[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 1) chk("mis_first_pc", {31'd0, s_valid[0], s_pc[0]}, {31'd0, 1'b1, 32'h8});
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset while entries are buffered and reads are in flight
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h100 + 32'(i * 4), 1'b0, (i == 4));
            if (i == 4) chk("mid_count_before", 64'(s_cnt[1]), 64'd2);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            chk("post_rst_valid", 64'(s_valid[1]), 64'd0);
            chk("post_rst_count", 64'(s_cnt[1]), 64'd0);
            chk("post_rst_flags", {62'd0, s_ovf[1], s_mis[1]}, 64'd0);
        end

        // Pointer wrap: alternating ready, sequential PCs must come out +4 each time
        for (int k = 0; k < 2; k++) begin
            prev[k] = 32'h200 - 32'd4;
            npop[k] = 0;
        end
        for (int i = 0; i < 40; i++) begin
            cycle((i % 2) == 0, 32'h200 + 32'((i / 2) * 4), (i % 2) == 1, 1'b0);
            for (int k = 0; k < 2; k++) begin
                if (s_valid[k] && (i % 2) == 1) begin
                    chk("wrap_seq", 64'(s_pc[k]), 64'(prev[k] + 32'd4));
                    prev[k] = s_pc[k];
                    npop[k]++;
                end
            end
        end
        chk("wrap_pops[0]", 64'(npop[0] > 3 * DEPTH), 64'd1);
        chk("wrap_pops[1]", 64'(npop[1] > 3 * DEPTH), 64'd1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        rp = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            ce  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 96) == 0);
            cycle(ce, rp | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0), rdy, rst);
            if (ce) rp = rp + 32'd4;
        end
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
